wb_nn_master: RTL and testbench

- Wishbone classic (B4, non-pipelined) initiator that moves a commanded number of 32-bit words between local valid/ready streams and a Wishbone responder, such as the NN input-FIFO slave.
- Sits beside the NN core. It lets on-chip logic push input words into, or pull result words out of, a memory-mapped NN port without firmware involvement.
- Handles one command at a time. Address is fixed or incrementing, and bus error or timeout causes an abort.

---
 rtl/wb_nn_pkg.sv | 15 +
 rtl/wb_nn_master_watchdog.sv | 42 ++++
 rtl/wb_nn_master.sv | 157 +++++++++++++++
 tb/tb_wb_nn_master.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_nn_pkg.sv
// Shared types and constants for the Wishbone NN stream master.
package wb_nn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    BUS   = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } wb_nn_mst_state_t;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;
  localparam int         WB_DATA_W  = 32;

endpackage

// File: rtl/wb_nn_master_watchdog.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the LIMIT-th cycle is reached. LIMIT=0 disables it.
module wb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW     = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam int LAST_I = (LIMIT == 0) ? 0 : LIMIT - 1;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count enabled cycles and park at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is combinational so the master leaves BUS after exactly LIMIT cycles.
  assign expired = (LIMIT != 0) && en && (cnt_q == LAST);

endmodule

// File: rtl/wb_nn_master.sv
// Wishbone classic single-beat initiator moving cmd_len words between the
// local write/read streams and a responder, with error/timeout abort.
module wb_nn_master
  import wb_nn_pkg::*;
#(
  parameter logic [31:0] ADDR_INCR      = 32'd0,
  parameter int          LEN_W          = 8,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [31:0]          cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [WB_DATA_W-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WB_DATA_W-1:0] rd_data,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_adr_o,
  output logic [WB_DATA_W-1:0] wbm_dat_o,
  input  logic [WB_DATA_W-1:0] wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  wb_nn_mst_state_t     state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic                 write_q, write_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [WB_DATA_W-1:0] wdat_q, wdat_d;
  logic [WB_DATA_W-1:0] rdat_q, rdat_d;
  logic                 error_q, error_d;
  logic                 wd_expired;

  wb_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (state_q != BUS),
    .en      (state_q == BUS),
    .expired (wd_expired)
  );

  // Next-state logic: command latch, write fetch, single-beat bus cycle, read hold.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    len_d   = len_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          write_d = cmd_write;
          len_d   = cmd_len;
          error_d = 1'b0;
          if (cmd_len == '0) begin
            state_d = DONE;
          end else if (cmd_write) begin
            state_d = FETCH;
          end else begin
            state_d = BUS;
          end
        end
      end
      FETCH: begin
        if (wr_valid) begin
          wdat_d  = wr_data;
          state_d = BUS;
        end
      end
      BUS: begin
        // Error (bus or watchdog) beats a simultaneous ack; no data captured.
        if (wbm_err_i || wd_expired) begin
          error_d = 1'b1;
          state_d = DONE;
        end else if (wbm_ack_i) begin
          len_d  = len_q - 1'b1;
          addr_d = addr_q + ADDR_INCR;
          if (!write_q) begin
            rdat_d  = wbm_dat_i;
            state_d = HOLD;
          end else if (len_q == LEN_ONE) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HOLD: begin
        if (rd_ready) begin
          state_d = (len_q == '0) ? DONE : BUS;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      len_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      len_q   <= len_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      error_q <= error_d;
    end
  end

  // Outputs are decoded from the state register so they clear with reset.
  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == FETCH);
  assign rd_valid  = (state_q == HOLD);
  assign rd_data   = (state_q == HOLD) ? rdat_q : '0;
  assign wbm_cyc_o = (state_q == BUS);
  assign wbm_stb_o = (state_q == BUS);
  assign wbm_we_o  = (state_q == BUS) && write_q;
  assign wbm_sel_o = (state_q == BUS) ? WB_SEL_ALL : 4'h0;
  assign wbm_adr_o = (state_q == BUS) ? addr_q : '0;
  assign wbm_dat_o = (state_q == BUS) ? wdat_q : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign error     = error_q;

endmodule

// File: tb/tb_wb_nn_master.sv
`timescale 1ns/1ps
// Scoreboard bench for wb_nn_master: commands push expected bus beats, read
// words and done/error results; a monitor pops and compares as they appear.
module tb_wb_nn_master;

  localparam logic [31:0] INCR = 32'd1;
  localparam int          TMO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid, rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
  logic        busy, done, error;

  always #5 clk = ~clk;

  wb_nn_master #(
    .ADDR_INCR(INCR), .LEN_W(8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .busy(busy), .done(done), .error(error)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  beat_t       exp_bus[$];
  logic [31:0] exp_rd[$];
  logic        exp_done[$];
  logic [31:0] wr_src[$];
  logic [31:0] rd_src[$];
  logic [31:0] preset[$];

  int vectors = 0;
  int errs    = 0;

  // Responder / stream configuration
  int err_at = 0;
  bit noack = 0, err_both = 0;
  int wait_max = 0, wr_pct = 100, rd_pct = 100, stall_first = 0, stall_cnt = 0;
  int beat_no = 0, wcnt = 0, wcur = 0;

  // Per-command observation counters
  int n_beats = 0, n_wr = 0, n_rd = 0, n_done = 0, cyc_cnt = 0, n_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Wishbone responder: optional wait states, error on beat err_at, or never ack.
  initial forever begin
    @(negedge clk);
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = $urandom;
    if (!rst && wbm_cyc_o && wbm_stb_o && !noack) begin
      if (wcnt < wcur) begin
        wcnt++;
      end else begin
        beat_no++;
        if (beat_no == err_at) begin
          wbm_err_i = 1'b1;
          wbm_ack_i = err_both;
        end else begin
          wbm_ack_i = 1'b1;
          if (!wbm_we_o && rd_src.size() > 0) wbm_dat_i = rd_src.pop_front();
        end
        wcnt = 0;
        wcur = $urandom_range(0, wait_max);
      end
    end
  end

  // Write-stream source
  initial forever begin
    @(negedge clk);
    if (!rst && wr_src.size() > 0 && int'($urandom_range(0, 99)) < wr_pct) begin
      wr_valid = 1'b1;
      wr_data  = wr_src[0];
    end else begin
      wr_valid = 1'b0;
      wr_data  = $urandom;
    end
  end

  // Read-stream sink with optional stall after the first word
  initial forever begin
    @(negedge clk);
    if (stall_cnt > 0) begin
      rd_ready = 1'b0;
      stall_cnt--;
    end else begin
      rd_ready = (int'($urandom_range(0, 99)) < rd_pct);
    end
  end

  // Monitor: invariants plus scoreboard pops on beats, read words and done.
  initial begin
    logic        p_pend, p_rpend, p_we;
    logic [31:0] p_adr, p_dat, p_rd, tmp;
    beat_t       b;
    p_pend = 0; p_rpend = 0; p_we = 0; p_adr = 0; p_dat = 0; p_rd = 0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        p_pend = 0;
        p_rpend = 0;
      end else begin
        if (wbm_cyc_o) cyc_cnt++;
        if (rd_valid && !rd_ready) n_stall++;
        chk("cyc_eq_stb", {31'd0, wbm_stb_o}, {31'd0, wbm_cyc_o});
        if (wbm_cyc_o) begin
          chk("bus_sel", {28'd0, wbm_sel_o}, 32'hF);
          chk("bus_exclusive", {29'd0, rd_valid, wr_ready, done}, 32'd0);
        end
        if (!busy) chk("idle_quiet", {28'd0, wbm_cyc_o, rd_valid, wr_ready, done}, 32'd0);
        if (p_pend && wbm_cyc_o) begin
          chk("adr_stable", wbm_adr_o, p_adr);
          chk("dat_stable", wbm_dat_o, p_dat);
          chk("we_stable", {31'd0, wbm_we_o}, {31'd0, p_we});
        end
        if (p_rpend && rd_valid) chk("rd_data_stable", rd_data, p_rd);
        if (wbm_cyc_o && wbm_stb_o && (wbm_ack_i || wbm_err_i)) begin
          n_beats++;
          if (exp_bus.size() == 0) begin
            chk("beat_unexpected", 32'd1, 32'd0);
          end else begin
            b = exp_bus.pop_front();
            chk("bus_we", {31'd0, wbm_we_o}, {31'd0, b.we});
            chk("bus_adr", wbm_adr_o, b.adr);
            if (b.we) chk("bus_dat", wbm_dat_o, b.dat);
          end
        end
        if (wr_valid && wr_ready) begin
          n_wr++;
          if (wr_src.size() > 0) tmp = wr_src.pop_front();
        end
        if (rd_valid && rd_ready) begin
          n_rd++;
          if (n_rd == 1) stall_cnt = stall_first;
          if (exp_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
          else chk("rd_data", rd_data, exp_rd.pop_front());
        end
        if (done) begin
          n_done++;
          if (exp_done.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
          else chk("done_error", {31'd0, error}, {31'd0, exp_done.pop_front()});
        end
        p_pend  = wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i;
        p_adr   = wbm_adr_o;
        p_dat   = wbm_dat_o;
        p_we    = wbm_we_o;
        p_rpend = rd_valid && !rd_ready;
        p_rd    = rd_data;
      end
    end
  end

  task automatic cleanup();
    wr_src.delete(); rd_src.delete(); preset.delete();
    exp_bus.delete(); exp_rd.delete(); exp_done.delete();
    err_at = 0; err_both = 0; noack = 0; stall_first = 0;
    wcnt = 0; wcur = 0; beat_no = 0;
  endtask

  // Issue one command, build its expectations from the transfer rules, and
  // wait (bounded) for done. exp_lat < 0 skips the cycle-count check.
  task automatic run_cmd(input bit w, input logic [31:0] a, input int n, input int exp_lat);
    int nb, ew, ecyc, nrd, lat;
    bit eerr, hit_err;
    logic [31:0] word;
    beat_t bb;
    beat_no = 0; wcnt = 0; wcur = 0;
    n_beats = 0; n_wr = 0; n_rd = 0; n_done = 0; cyc_cnt = 0; n_stall = 0;
    hit_err = (err_at > 0) && (err_at <= n);
    nb   = (n == 0 || noack) ? 0 : (hit_err ? err_at : n);
    eerr = (n > 0) && (noack || hit_err);
    nrd  = 0;
    for (int i = 0; i < n; i++) begin
      word = (preset.size() > 0) ? preset.pop_front() : $urandom;
      if (w) wr_src.push_back(word);
      else   rd_src.push_back(word);
      if (i < nb) begin
        bb.we  = w;
        bb.adr = a + INCR * 32'(i);
        bb.dat = w ? word : 32'd0;
        exp_bus.push_back(bb);
        if (!w && (err_at != i + 1)) begin
          exp_rd.push_back(word);
          nrd++;
        end
      end
    end
    ew   = (!w || n == 0) ? 0 : (noack ? 1 : nb);
    ecyc = (noack && n > 0) ? TMO : ((wait_max == 0) ? nb : -1);
    exp_done.push_back(eerr);

    cmd_write = w; cmd_addr = a; cmd_len = n[7:0]; cmd_valid = 1'b1;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = $urandom; cmd_addr = $urandom; cmd_len = $urandom;
    lat = 0;
    do begin
      @(negedge clk); #2;
      lat++;
      if (lat == 1) chk("error_cleared", {31'd0, error}, 32'd0);
    end while (!done && lat < 400);
    if (!done) begin
      chk("done_timeout", lat, 32'd0);
    end else begin
      if (exp_lat >= 0) chk("latency", lat, exp_lat);
      chk("busy_at_done", {31'd0, busy}, 32'd1);
    end
    chk("done_count", n_done, 32'd1);
    chk("bus_beats", n_beats, nb);
    chk("wr_handshakes", n_wr, ew);
    chk("rd_words", n_rd, nrd);
    chk("exp_bus_left", exp_bus.size(), 32'd0);
    if (ecyc >= 0) chk("cyc_cycles", cyc_cnt, ecyc);
    @(negedge clk); #2;
    chk("ready_after", {31'd0, cmd_ready}, 32'd1);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("done_width", {31'd0, done}, 32'd0);
    chk("error_hold", {31'd0, error}, {31'd0, eerr});
    $display("cmd %s addr=%h len=%0d lat=%0d beats=%0d err=%0b", w ? "WR" : "RD", a, n, lat, n_beats, error);
    cleanup();
  endtask

  // Global bound on simulation time
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, r;
    bit w;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_dat_o", wbm_dat_o, 32'd0);

    // Directed: same-cycle responder, streams always ready
    wait_max = 0; wr_pct = 100; rd_pct = 100;
    preset.push_back(32'hA); preset.push_back(32'hB); preset.push_back(32'hC);
    run_cmd(1'b1, 32'h3000_0000, 3, 7);

    stall_first = 5;
    run_cmd(1'b0, 32'h3000_0000, 2, -1);

    noack = 1;
    run_cmd(1'b1, 32'h3000_0010, 1, 2 + TMO);

    err_at = 2;
    run_cmd(1'b1, 32'h3000_0000, 4, 5);

    run_cmd(1'b0, 32'h0000_1234, 0, 1);

    err_at = 2; err_both = 1;
    run_cmd(1'b0, 32'h3000_0100, 3, 4);

    run_cmd(1'b0, 32'hFFFF_FFFF, 2, 5);

    // Asynchronous reset in the middle of a stuck write cycle
    noack = 1; n_done = 0;
    wr_src.push_back(32'h1234_5678);
    cmd_write = 1'b1; cmd_addr = 32'h4000_0000; cmd_len = 8'd2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_rst_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    chk("pre_rst_we", {31'd0, wbm_we_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("async_stb", {31'd0, wbm_stb_o}, 32'd0);
    chk("async_we", {31'd0, wbm_we_o}, 32'd0);
    chk("async_dat_o", wbm_dat_o, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cleanup();
    repeat (3) @(negedge clk);
    #2;
    chk("no_done_after_rst", n_done, 32'd0);
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
    run_cmd(1'b0, 32'h3000_0000, 3, 7);

    // Randomized commands
    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(0, 6);
      w = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      a = (r == 3) ? 32'hFFFF_FFFE : $urandom;
      wait_max = $urandom_range(0, 3);
      wr_pct   = $urandom_range(40, 100);
      rd_pct   = $urandom_range(40, 100);
      err_at   = (r < 2) ? int'($urandom_range(1, 4)) : 0;
      err_both = $urandom_range(0, 1);
      noack    = (r == 2);
      run_cmd(w, a, n, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
